ltc2308_ctrl: RTL and testbench

LTC2308_CTRL -- requirements
Module: ltc2308_ctrl

---
 rtl/ltc2308_ctrl.sv | 166 ++++++++++++++++
 tb/tb_ltc2308_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ltc2308_ctrl.sv
// ltc2308_ctrl
//   Frame sequencer for an LTC2308 ADC: pulses CONVST, waits out the
//   conversion time, then runs 12 SCK periods that shift the next 6-bit
//   config word out on SDI and the previous conversion in from SDO.
//   Each frame's SDO data belongs to the config sent in the frame before it.
//   For that reason, the first frame after reset or IDLE reports nothing.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   enable            run back-to-back frames while high
//   chan[2:0]         single-ended channel, latched at frame start
//   adc_convst/sck/sdi  outputs to the ADC (all registered)
//   adc_sdo           serial data from the ADC, MSB first
//   result[11:0]      last completed conversion (held between valids)
//   result_chan[2:0]  channel that result belongs to
//   valid             one-cycle pulse when result/result_chan update
//   busy              high whenever the FSM is not IDLE
module ltc2308_ctrl #(
  parameter int CLK_DIV       = 2,
  parameter int CONVST_CYCLES = 2,
  parameter int CONV_CYCLES   = 80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [2:0]  chan,
  output logic        adc_convst,
  output logic        adc_sck,
  output logic        adc_sdi,
  input  logic        adc_sdo,
  output logic [11:0] result,
  output logic [2:0]  result_chan,
  output logic        valid,
  output logic        busy
);

  localparam int CNT_MAX = (CONV_CYCLES > CONVST_CYCLES) ?
                           ((CONV_CYCLES > CLK_DIV) ? CONV_CYCLES : CLK_DIV) :
                           ((CONVST_CYCLES > CLK_DIV) ? CONVST_CYCLES : CLK_DIV);
  localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_SHIFT, S_DONE} state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [3:0]     bit_q;        // current SCK period, 0..11
  logic           convst_q, sck_q, sdi_q, valid_q;
  logic [2:0]     cfg_chan_q;   // channel programmed in this frame
  logic [2:0]     prev_chan_q;  // channel programmed in the previous frame
  logic           prev_vld_q;   // previous frame sent a config
  logic [11:0]    shreg_q, result_q;
  logic [2:0]     result_chan_q;

  // {S/D, O/S, S1, S0, UNI, SLP}
  logic [5:0] cfg_bits;
  assign cfg_bits = {1'b1, cfg_chan_q[0], cfg_chan_q[2], cfg_chan_q[1], 1'b1, 1'b0};

  // SDI value for the period that follows the current one
  logic [3:0] nxt_k;
  logic       sdi_d;
  always_comb begin
    nxt_k = bit_q + 4'd1;
    sdi_d = 1'b0;
    if (nxt_k < 4'd6) sdi_d = cfg_bits[3'(4'd5 - nxt_k)];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_q         <= '0;
      convst_q      <= 1'b0;
      sck_q         <= 1'b0;
      sdi_q         <= 1'b0;
      valid_q       <= 1'b0;
      cfg_chan_q    <= '0;
      prev_chan_q   <= '0;
      prev_vld_q    <= 1'b0;
      shreg_q       <= '0;
      result_q      <= '0;
      result_chan_q <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (enable) begin
            state_q    <= S_START;
            convst_q   <= 1'b1;
            cfg_chan_q <= chan;
            cnt_q      <= CW'(CONVST_CYCLES - 1);
          end
        end
        S_START: begin
          if (cnt_q == '0) begin
            state_q  <= S_WAIT;
            convst_q <= 1'b0;
            cnt_q    <= CW'(CONV_CYCLES - 1);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= S_SHIFT;
            sck_q   <= 1'b0;
            sdi_q   <= cfg_bits[5];
            bit_q   <= '0;
            cnt_q   <= CW'(CLK_DIV - 1);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_SHIFT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            cnt_q <= CW'(CLK_DIV - 1);
            if (!sck_q) begin
              // rising SCK: sample the ADC on the same edge
              sck_q   <= 1'b1;
              shreg_q <= {shreg_q[10:0], adc_sdo};
            end else begin
              // falling SCK: SDI only moves here, while SCK goes low
              sck_q <= 1'b0;
              if (bit_q == 4'd11) begin
                state_q     <= S_DONE;
                sdi_q       <= 1'b0;
                prev_chan_q <= cfg_chan_q;
                prev_vld_q  <= 1'b1;
                if (prev_vld_q) begin
                  result_q      <= shreg_q;
                  result_chan_q <= prev_chan_q;
                  valid_q       <= 1'b1;
                end
              end else begin
                bit_q <= nxt_k;
                sdi_q <= sdi_d;
              end
            end
          end
        end
        S_DONE: begin
          if (enable) begin
            state_q    <= S_START;
            convst_q   <= 1'b1;
            cfg_chan_q <= chan;
            cnt_q      <= CW'(CONVST_CYCLES - 1);
          end else begin
            state_q    <= S_IDLE;
            prev_vld_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign adc_convst  = convst_q;
  assign adc_sck     = sck_q;
  assign adc_sdi     = sdi_q;
  assign result      = result_q;
  assign result_chan = result_chan_q;
  assign valid       = valid_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_ltc2308_ctrl.sv
// Directed bench for ltc2308_ctrl: a default-parameter instance plus a
// fast instance (CLK_DIV=1, CONVST_CYCLES=1, CONV_CYCLES=1), each driven by
// a small ADC model that always returns 0xA5C and records the SDI bits.
module tb_ltc2308_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, enable, en_f;
  logic [2:0]  chan;
  logic        convst, sck, sdi, sdo, valid, busy;
  logic [11:0] result;
  logic [2:0]  result_chan;
  logic        convst_f, sck_f, sdi_f, sdo_f, valid_f, busy_f;
  logic [11:0] result_f;
  logic [2:0]  result_chan_f;

  int n_assert = 0;
  int n_fail   = 0;

  ltc2308_ctrl u_dut (
    .clk(clk), .reset(reset), .enable(enable), .chan(chan),
    .adc_convst(convst), .adc_sck(sck), .adc_sdi(sdi), .adc_sdo(sdo),
    .result(result), .result_chan(result_chan), .valid(valid), .busy(busy)
  );

  ltc2308_ctrl #(.CLK_DIV(1), .CONVST_CYCLES(1), .CONV_CYCLES(1)) u_fast (
    .clk(clk), .reset(reset), .enable(en_f), .chan(chan),
    .adc_convst(convst_f), .adc_sck(sck_f), .adc_sdi(sdi_f), .adc_sdo(sdo_f),
    .result(result_f), .result_chan(result_chan_f), .valid(valid_f), .busy(busy_f)
  );

  // ADC models: a CONVST rise restarts the frame; each SCK rise consumes
  // one SDO bit and records one SDI bit.
  logic [11:0] adc_word = 12'hA5C;
  int          idx = 0, idx_f = 0;
  logic [11:0] sdi_sh = '0, sdi_sh_f = '0;

  always @(posedge convst or posedge sck)
    if (convst) begin idx = 0; sdi_sh = '0; end
    else begin sdi_sh = {sdi_sh[10:0], sdi}; idx++; end

  always @(posedge convst_f or posedge sck_f)
    if (convst_f) begin idx_f = 0; sdi_sh_f = '0; end
    else begin sdi_sh_f = {sdi_sh_f[10:0], sdi_f}; idx_f++; end

  assign sdo   = (idx   < 12) ? adc_word[11-idx]   : 1'b0;
  assign sdo_f = (idx_f < 12) ? adc_word[11-idx_f] : 1'b0;

  // SDI must never move while SCK is high
  int   sdi_viol = 0;
  logic sdi_prev = 1'b0, sdi_prev_f = 1'b0;
  always @(negedge clk) begin
    if (sdi !== sdi_prev && sck === 1'b1) sdi_viol++;
    if (sdi_f !== sdi_prev_f && sck_f === 1'b1) sdi_viol++;
    sdi_prev   = sdi;
    sdi_prev_f = sdi_f;
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int bound, output int n);
    n = 0;
    do begin tick(); n++; end while (valid !== 1'b1 && n < bound);
  endtask

  task automatic wait_valid_f(input int bound, output int n);
    n = 0;
    do begin tick(); n++; end while (valid_f !== 1'b1 && n < bound);
  endtask

  // Expected SDI words come from {S/D=1, O/S=c[0], S1=c[2], S0=c[1], UNI=1, SLP=0}:
  // chan 3 -> 110110, 5 -> 111010, 2 -> 100110, 7 -> 111110, 1 -> 110010.
  initial begin
    int n, cnt_bad;
    reset = 1'b1; enable = 1'b0; en_f = 1'b0; chan = 3'd3;
    repeat (3) tick();
    chk("reset_outputs", {convst, sck, sdi, valid, busy, result, result_chan}, 32'h0);
    chk("reset_fast_busy", busy_f, 1'b0);

    // enable with chan=3: first valid at end of frame 2
    reset = 1'b0; tick();
    enable = 1'b1;
    wait_valid(400, n);
    chk("first_valid_cycle", n, 262);
    chk("v1_result", result, 12'hA5C);
    chk("v1_chan", result_chan, 3'd3);
    chk("v1_sdi_word", sdi_sh, {6'b110110, 6'b000000});
    chk("v1_sck_rises", idx, 12);
    wait_valid(200, n);
    chk("frame_period", n, 131);
    chk("v2_chan", result_chan, 3'd3);

    // chan=5 for the next frame, then 2
    chan = 3'd5;
    tick();
    chk("valid_one_cycle", valid, 1'b0);
    chk("done_to_start", {busy, convst}, 2'b11);
    wait_valid(200, n);
    chk("v3_seen", valid, 1'b1);
    chk("v3_sdi_chan5", sdi_sh[11:6], 6'b111010);
    chk("v3_chan", result_chan, 3'd3);
    chan = 3'd2;
    wait_valid(200, n);
    chk("v4_sdi_chan2", sdi_sh[11:6], 6'b100110);
    chk("v4_chan", result_chan, 3'd5);

    // chan -> 7 during WAIT does not touch the running frame
    repeat (10) tick();
    chan = 3'd7;
    chk("hold_result", result, 12'hA5C);
    chk("hold_chan", result_chan, 3'd5);
    wait_valid(200, n);
    chk("v5_sdi_still2", sdi_sh[11:6], 6'b100110);
    chk("v5_chan", result_chan, 3'd2);
    wait_valid(200, n);
    chk("v6_sdi_chan7", sdi_sh[11:6], 6'b111110);
    chk("v6_chan", result_chan, 3'd2);

    // drop enable in SHIFT: frame completes, then idle
    repeat (92) tick();
    chk("in_shift_busy", busy, 1'b1);
    enable = 1'b0;
    wait_valid(100, n);
    chk("drop_valid", valid, 1'b1);
    chk("drop_chan", result_chan, 3'd7);
    chk("drop_rises", idx, 12);
    tick();
    chk("drop_busy_low", {busy, convst, sck, sdi}, 4'b0000);
    cnt_bad = 0;
    repeat (300) begin tick(); if (convst !== 1'b0 || valid !== 1'b0) cnt_bad++; end
    chk("idle_quiet", cnt_bad, 0);

    // reset in the SHIFT of frame 2 (prior config valid): restart gives no early valid
    chan = 3'd1; enable = 1'b1;
    cnt_bad = 0;
    repeat (231) begin tick(); if (valid !== 1'b0) cnt_bad++; end
    chk("pre_reset_no_valid", cnt_bad, 0);
    chk("pre_reset_shift", busy, 1'b1);
    reset = 1'b1;
    tick();
    chk("midreset_outputs", {convst, sck, sdi, valid, busy, result, result_chan}, 32'h0);
    reset = 1'b0;
    wait_valid(400, n);
    chk("restart_first_valid", n, 262);
    chk("restart_chan", result_chan, 3'd1);
    enable = 1'b0;

    // fast instance: 27-cycle frames
    en_f = 1'b1;
    wait_valid_f(200, n);
    chk("fast_first_valid", n, 54);
    chk("fast_result", result_f, 12'hA5C);
    chk("fast_rises", idx_f, 12);
    chk("fast_sdi_chan1", sdi_sh_f[11:6], 6'b110010);
    wait_valid_f(100, n);
    chk("fast_period", n, 27);
    chk("fast_chan", result_chan_f, 3'd1);
    en_f = 1'b0;
    repeat (40) tick();

    chk("sdi_stable_high", sdi_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
